// File: rtl/otter_pkg.sv
// Shared OTTER encodings: RV32I opcodes, SYSTEM funct3 values and the control-unit state set.
package otter_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_OP     = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    F3_MRET   = 3'b000,
    F3_CSRRW  = 3'b001,
    F3_CSRRS  = 3'b010,
    F3_CSRRC  = 3'b011,
    F3_CSRRWI = 3'b101,
    F3_CSRRSI = 3'b110,
    F3_CSRRCI = 3'b111
  } funct3_system_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2,
    ST_INTR  = 2'd3
  } cu_state_t;

endpackage

// File: rtl/otter_cu_fsm_if.sv
// Control-unit bus: decode/memory/interrupt inputs and strobe outputs.
interface otter_cu_fsm_if;
  logic [6:0] CU_OPCODE;
  logic [2:0] CU_FUNC3;
  logic       CU_INT;
  logic       CU_MIE;
  logic       CU_MEM_RDY;
  logic       CU_PCWRITE;
  logic       CU_REGWRITE;
  logic       CU_MEMREAD1;
  logic       CU_MEMREAD2;
  logic       CU_MEMWRITE;
  logic       CU_CSR_WRITE;
  logic       CU_INT_TAKEN;
  logic [1:0] CU_STATE;

  // master: datapath/memory side driving the control unit
  modport master (
    output CU_OPCODE, CU_FUNC3, CU_INT, CU_MIE, CU_MEM_RDY,
    input  CU_PCWRITE, CU_REGWRITE, CU_MEMREAD1, CU_MEMREAD2,
           CU_MEMWRITE, CU_CSR_WRITE, CU_INT_TAKEN, CU_STATE
  );

  modport slave (
    input  CU_OPCODE, CU_FUNC3, CU_INT, CU_MIE, CU_MEM_RDY,
    output CU_PCWRITE, CU_REGWRITE, CU_MEMREAD1, CU_MEMREAD2,
           CU_MEMWRITE, CU_CSR_WRITE, CU_INT_TAKEN, CU_STATE
  );
endinterface

// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control unit: FETCH/EXEC/WB/INTR sequencer with memory-ready stalls.
module otter_cu_fsm
  import otter_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  otter_cu_fsm_if.slave   bus
);

  cu_state_t state, nxt;
  logic      done;
  logic      pcw, regw, mr1, mr2, mw, csr, itk;

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_FETCH;
    else     state <= nxt;
  end

  always_comb begin
    nxt  = state;
    done = 1'b0;
    pcw  = 1'b0;
    regw = 1'b0;
    mr1  = 1'b0;
    mr2  = 1'b0;
    mw   = 1'b0;
    csr  = 1'b0;
    itk  = 1'b0;
    case (state)
      ST_FETCH: begin
        mr1 = 1'b1;
        if (bus.CU_MEM_RDY) nxt = ST_EXEC;
      end
      ST_EXEC: begin
        case (opcode_t'(bus.CU_OPCODE))
          OP_LOAD: begin
            mr2 = 1'b1;
            nxt = ST_WB;
          end
          OP_STORE: begin
            mw   = 1'b1;
            pcw  = bus.CU_MEM_RDY;
            done = bus.CU_MEM_RDY;
          end
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OP, OP_IMM: begin
            pcw  = 1'b1;
            regw = 1'b1;
            done = 1'b1;
          end
          OP_SYSTEM: begin
            pcw  = 1'b1;
            done = 1'b1;
            if (funct3_system_t'(bus.CU_FUNC3) != F3_MRET) begin
              regw = 1'b1;
              csr  = 1'b1;
            end
          end
          // BRANCH and unrecognised opcodes only advance the PC
          default: begin
            pcw  = 1'b1;
            done = 1'b1;
          end
        endcase
      end
      ST_WB: begin
        mr2 = 1'b1;
        if (bus.CU_MEM_RDY) begin
          regw = 1'b1;
          pcw  = 1'b1;
          done = 1'b1;
        end
      end
      ST_INTR: begin
        pcw = 1'b1;
        itk = 1'b1;
        nxt = ST_FETCH;
      end
      default: nxt = ST_FETCH;
    endcase
    // interrupts are only honoured at an instruction boundary
    if (done) nxt = (bus.CU_INT && bus.CU_MIE) ? ST_INTR : ST_FETCH;
  end

  // reset masks every strobe so an abandoned instruction writes nothing
  assign bus.CU_PCWRITE   = pcw  & ~RST;
  assign bus.CU_REGWRITE  = regw & ~RST;
  assign bus.CU_MEMREAD1  = mr1  & ~RST;
  assign bus.CU_MEMREAD2  = mr2  & ~RST;
  assign bus.CU_MEMWRITE  = mw   & ~RST;
  assign bus.CU_CSR_WRITE = csr  & ~RST;
  assign bus.CU_INT_TAKEN = itk  & ~RST;
  assign bus.CU_STATE     = RST ? 2'd0 : state;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed vector table plus randomized run against an instruction-level reference model.
module tb_otter_cu_fsm;

  // expected output word: {pcwrite, regwrite, memread1, memread2, memwrite, csr_write, int_taken}
  localparam logic [6:0] Z      = 7'b0000000;
  localparam logic [6:0] MR1    = 7'b0010000;
  localparam logic [6:0] ALU    = 7'b1100000;
  localparam logic [6:0] PCW    = 7'b1000000;
  localparam logic [6:0] MR2    = 7'b0001000;
  localparam logic [6:0] WBDONE = 7'b1101000;
  localparam logic [6:0] MW     = 7'b0000100;
  localparam logic [6:0] MWDONE = 7'b1000100;
  localparam logic [6:0] CSRW   = 7'b1100010;
  localparam logic [6:0] INTR   = 7'b1000001;

  localparam logic [6:0] O_OP   = 7'b0110011;
  localparam logic [6:0] O_LD   = 7'b0000011;
  localparam logic [6:0] O_ST   = 7'b0100011;
  localparam logic [6:0] O_BR   = 7'b1100011;
  localparam logic [6:0] O_SYS  = 7'b1110011;
  localparam logic [6:0] O_BAD  = 7'b0001111;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       irq, mie, rdy;
    logic [1:0] es;
    logic [6:0] eo;
    string      nm;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  otter_cu_fsm_if bus();
  otter_cu_fsm dut (.CLK(CLK), .RST(RST), .bus(bus));

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t tbl[$];

  function automatic logic [6:0] outs();
    return {bus.CU_PCWRITE, bus.CU_REGWRITE, bus.CU_MEMREAD1, bus.CU_MEMREAD2,
            bus.CU_MEMWRITE, bus.CU_CSR_WRITE, bus.CU_INT_TAKEN};
  endfunction

  function automatic void v(logic rst, logic [6:0] op, logic [2:0] f3, logic irq, logic mie,
                            logic rdy, logic [1:0] es, logic [6:0] eo, string nm);
    vec_t t;
    t.rst = rst; t.op = op; t.f3 = f3; t.irq = irq; t.mie = mie; t.rdy = rdy;
    t.es = es; t.eo = eo; t.nm = nm;
    tbl.push_back(t);
  endfunction

  // drive one cycle, check mid-cycle, then let the edge happen
  task automatic apply(input vec_t t);
    RST = t.rst;
    bus.CU_OPCODE = t.op;  bus.CU_FUNC3 = t.f3;
    bus.CU_INT = t.irq;    bus.CU_MIE = t.mie;  bus.CU_MEM_RDY = t.rdy;
    @(negedge CLK);
    n_chk++;
    if ({bus.CU_STATE, outs()} !== {t.es, t.eo}) begin
      n_fail++;
      $display("FAIL %s: state=%0d outs=%b, required state=%0d outs=%b",
               t.nm, bus.CU_STATE, outs(), t.es, t.eo);
    end
    @(posedge CLK); #1;
  endtask

  // Reference: what an instruction of this opcode does in a given phase of its life.
  function automatic bit writes_rd(logic [6:0] op, logic [2:0] f3);
    logic [6:0] rd_ops [6] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0110011, 7'b0010011};
    foreach (rd_ops[i]) if (op == rd_ops[i]) return 1'b1;
    return (op == O_SYS) && (f3 != 3'b000);
  endfunction

  function automatic void model(input int ph, input logic [6:0] op, input logic [2:0] f3,
                                input logic rdy, output logic [6:0] o, output int nxt,
                                output bit done);
    o = Z; nxt = ph; done = 1'b0;
    if (ph == 0) begin
      o = MR1;
      if (rdy) nxt = 1;
    end else if (ph == 1) begin
      if (op == O_LD) begin
        o = MR2; nxt = 2;
      end else if (op == O_ST) begin
        o = rdy ? MWDONE : MW; done = rdy;
      end else begin
        done = 1'b1;
        if (!writes_rd(op, f3)) o = PCW;
        else                    o = (op == O_SYS) ? CSRW : ALU;
      end
    end else if (ph == 2) begin
      o = rdy ? WBDONE : MR2; done = rdy;
    end else begin
      o = INTR; nxt = 0;
    end
  endfunction

  initial begin
    logic [6:0] ops [12] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, O_BR, O_LD,
                             O_ST, 7'b0010011, O_OP, O_SYS, O_BAD, 7'b0000000};
    int         ph;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    vec_t       t;
    logic [6:0] eo;
    int         nxt;
    bit         done;

    // reset held two cycles, then an OP instruction
    v(1, O_OP, 0, 0, 0, 1, 0, Z,   "rst_c0");
    v(1, O_OP, 0, 0, 0, 1, 0, Z,   "rst_c1");
    v(0, O_OP, 0, 0, 0, 1, 0, MR1, "op_fetch");
    v(0, O_OP, 0, 0, 0, 1, 1, ALU, "op_exec");
    // load with two WB wait cycles
    v(0, O_LD, 0, 0, 0, 1, 0, MR1,    "ld_fetch");
    v(0, O_LD, 0, 0, 0, 0, 1, MR2,    "ld_exec");
    v(0, O_LD, 0, 0, 0, 0, 2, MR2,    "ld_wb_wait0");
    v(0, O_LD, 0, 0, 0, 0, 2, MR2,    "ld_wb_wait1");
    v(0, O_LD, 0, 0, 0, 1, 2, WBDONE, "ld_wb_done");
    // store with one EXEC wait
    v(0, O_ST, 0, 0, 0, 1, 0, MR1,    "st_fetch");
    v(0, O_ST, 0, 0, 0, 0, 1, MW,     "st_exec_wait");
    v(0, O_ST, 0, 0, 0, 1, 1, MWDONE, "st_exec_done");
    // fetch stall then branch with interrupt taken
    v(0, O_BR, 0, 1, 1, 0, 0, MR1,  "br_fetch_stall");
    v(0, O_BR, 0, 1, 1, 1, 0, MR1,  "br_fetch");
    v(0, O_BR, 0, 1, 1, 1, 1, PCW,  "br_exec_irq");
    v(0, O_BR, 0, 1, 1, 1, 3, INTR, "intr");
    // same branch, interrupt masked
    v(0, O_BR, 0, 1, 0, 1, 0, MR1,  "br_fetch_masked");
    v(0, O_BR, 0, 1, 0, 1, 1, PCW,  "br_exec_masked");
    // CSR vs mret
    v(0, O_SYS, 3'b001, 0, 0, 1, 0, MR1,  "csr_fetch");
    v(0, O_SYS, 3'b001, 0, 0, 1, 1, CSRW, "csr_exec");
    v(0, O_SYS, 3'b000, 0, 0, 1, 0, MR1,  "mret_fetch");
    v(0, O_SYS, 3'b000, 0, 0, 1, 1, PCW,  "mret_exec");
    // unrecognised opcode is a NOP
    v(0, O_BAD, 0, 0, 0, 1, 0, MR1, "nop_fetch");
    v(0, O_BAD, 0, 0, 0, 1, 1, PCW, "nop_exec");
    // interrupt raised mid-load waits until the load completes
    v(0, O_LD, 0, 1, 1, 1, 0, MR1,    "ldi_fetch");
    v(0, O_LD, 0, 1, 1, 0, 1, MR2,    "ldi_exec");
    v(0, O_LD, 0, 1, 1, 0, 2, MR2,    "ldi_wb_wait");
    v(0, O_LD, 0, 1, 1, 1, 2, WBDONE, "ldi_wb_done");
    v(0, O_LD, 0, 1, 1, 1, 3, INTR,   "ldi_intr");
    // reset during a stalled WB
    v(0, O_LD, 0, 0, 0, 1, 0, MR1, "ldr_fetch");
    v(0, O_LD, 0, 0, 0, 0, 1, MR2, "ldr_exec");
    v(0, O_LD, 0, 0, 0, 0, 2, MR2, "ldr_wb_wait");
    v(1, O_LD, 0, 0, 0, 1, 0, Z,   "ldr_rst");
    v(0, O_LD, 0, 0, 0, 1, 0, MR1, "ldr_after_rst");

    foreach (tbl[i]) apply(tbl[i]);

    // randomized: re-synchronise with a reset, then free-run against the model
    t = '{rst: 1'b1, op: O_OP, f3: 3'd0, irq: 1'b0, mie: 1'b0, rdy: 1'b0,
          es: 2'd0, eo: Z, nm: "rand_sync"};
    apply(t);
    ph = 0;
    cur_op = O_OP;
    cur_f3 = 3'd0;
    for (int c = 0; c < 2000; c++) begin
      if (ph == 0) begin
        cur_op = ops[$urandom_range(0, 11)];
        cur_f3 = 3'($urandom_range(0, 3));
      end
      t.rst = ($urandom_range(0, 39) == 0);
      t.op  = cur_op;
      t.f3  = cur_f3;
      t.irq = $urandom_range(0, 3) == 0;
      t.mie = $urandom_range(0, 1) == 1;
      t.rdy = $urandom_range(0, 4) < 3;
      t.nm  = "rand";
      model(ph, t.op, t.f3, t.rdy, eo, nxt, done);
      t.es = t.rst ? 2'd0 : 2'(ph);
      t.eo = t.rst ? Z : eo;
      apply(t);
      if (t.rst)     ph = 0;
      else if (done) ph = (t.irq && t.mie) ? 3 : 0;
      else           ph = nxt;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/otter_cu_fsm.md
OTTER_CU_FSM -- requirements
Module: otter_cu_fsm

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port CU_OPCODE, input, 7 bits: opcode of the current instruction (RV32I encodings).
REQ-005 The block SHALL have port CU_FUNC3, input, 3 bits: funct3 of the current instruction.
REQ-006 The block SHALL have port CU_INT, input, 1 bit: level-sensitive interrupt request.
REQ-007 The block SHALL have port CU_MIE, input, 1 bit: interrupt enable, taken from the CSR file.
REQ-008 The block SHALL have port CU_MEM_RDY, input, 1 bit: memory has completed the current request.
REQ-009 The block SHALL have port CU_PCWRITE, output, 1 bit: PC register load enable.
REQ-010 The block SHALL have port CU_REGWRITE, output, 1 bit: register-file write enable.
REQ-011 The block SHALL have port CU_MEMREAD1, output, 1 bit: instruction-fetch read request.
REQ-012 The block SHALL have port CU_MEMREAD2, output, 1 bit: data read request.
REQ-013 The block SHALL have port CU_MEMWRITE, output, 1 bit: data write request.
REQ-014 The block SHALL have port CU_CSR_WRITE, output, 1 bit: CSR write enable.
REQ-015 The block SHALL have port CU_INT_TAKEN, output, 1 bit: interrupt-entry strobe.
REQ-016 The block SHALL have port CU_STATE, output, 2 bits: current state, for debug.

Function
REQ-017 The FSM SHALL have four states: FETCH=0, EXEC=1, WB=2, INTR=3. Outputs SHALL be combinational from state, CU_OPCODE, CU_FUNC3 and CU_MEM_RDY; every output not named in a state below SHALL be 0.
REQ-018 In FETCH, the FSM SHALL assert CU_MEMREAD1, hold FETCH while CU_MEM_RDY=0, and go to EXEC on CU_MEM_RDY=1.
REQ-019 In EXEC with LOAD: assert CU_MEMREAD2; next state WB.
REQ-020 In EXEC with STORE: assert CU_MEMWRITE; hold EXEC while CU_MEM_RDY=0; assert CU_PCWRITE only in the cycle CU_MEM_RDY=1, then complete.
REQ-021 In EXEC with LUI, AUIPC, JAL, JALR, OP or OP_IMM: assert CU_PCWRITE and CU_REGWRITE; complete.
REQ-022 In EXEC with BRANCH: assert CU_PCWRITE only; complete.
REQ-023 In EXEC with SYSTEM: when CU_FUNC3 is not 000 (CSR instruction), assert CU_PCWRITE, CU_REGWRITE and CU_CSR_WRITE; when CU_FUNC3=000 (mret), assert CU_PCWRITE only. Complete in both cases.
REQ-024 In EXEC with an unrecognised opcode: treat as a NOP (CU_PCWRITE only); complete.
REQ-025 In WB: assert CU_MEMREAD2 and hold WB while CU_MEM_RDY=0; in the cycle CU_MEM_RDY=1, assert CU_REGWRITE and CU_PCWRITE, then complete.
REQ-026 On completion, the next state SHALL be INTR if CU_INT and CU_MIE are both 1 in the completing cycle, otherwise FETCH.
REQ-027 The interrupt SHALL be sampled only at completion; assertion mid-instruction SHALL NOT abort the instruction.
REQ-028 In INTR: assert CU_PCWRITE and CU_INT_TAKEN for exactly one cycle; next state FETCH.
REQ-029 CU_INT_TAKEN SHALL never be asserted in the same cycle as CU_REGWRITE, CU_MEMWRITE or CU_CSR_WRITE.
REQ-030 Latency SHALL be, with zero memory wait: 2 cycles for ALU/branch/jump/CSR/store instructions, 3 for LOAD, and +1 when an interrupt is taken.
REQ-031 Each cycle of CU_MEM_RDY=0 in FETCH, a STORE in EXEC, or WB SHALL add one cycle; the stall count is unbounded.

Reset
REQ-032 When RST=1 at a rising CLK edge, state SHALL become FETCH, regardless of the current state.
REQ-033 While RST=1, all outputs SHALL be forced to 0, including CU_MEMREAD1.
REQ-034 Reset mid-instruction SHALL abandon the instruction without issuing any write strobe in the reset cycle.
REQ-035 In the first cycle after RST falls, CU_MEMREAD1=1, CU_STATE=0, and all other outputs SHALL be 0.

Structure
REQ-036 The opcode_t enum, funct3_system_t enum and the state enum SHALL live in the shared package otter_pkg, reused by the decoder.
REQ-037 The block SHALL contain one state register plus combinational next-state and output logic; no sub-module is required.

Verification
REQ-038 Reset and fetch: hold RST=1 for 2 cycles, then release with CU_MEM_RDY=1 and CU_OPCODE=0110011 -> CU_STATE sequence 0,1,0; CU_REGWRITE=1 and CU_PCWRITE=1 in the EXEC cycle only.
REQ-039 Load with wait: CU_OPCODE=0000011, CU_MEM_RDY low for 2 WB cycles -> CU_MEMREAD2 high for 4 cycles; CU_REGWRITE asserted once, in the cycle CU_MEM_RDY=1; 5 cycles total.
REQ-040 Store: CU_OPCODE=0100011, CU_MEM_RDY=0 for 1 EXEC cycle -> CU_MEMWRITE high 2 cycles; CU_PCWRITE high only in the second; CU_REGWRITE stays 0.
REQ-041 Interrupt: CU_INT=1 and CU_MIE=1 while a BRANCH executes -> EXEC, then INTR with CU_INT_TAKEN=1 for 1 cycle, then FETCH. With CU_MIE=0 -> no INTR.
REQ-042 CSR versus mret: SYSTEM with CU_FUNC3=001 -> CU_CSR_WRITE=1 and CU_REGWRITE=1; CU_FUNC3=000 -> both 0 and CU_PCWRITE=1.
REQ-043 Reset during WB with CU_MEM_RDY=0: assert RST for 1 cycle -> no CU_REGWRITE; CU_STATE=0 afterwards.
